// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner: FSM state codes,
// the dark cathode pattern and counter width helper.
package seven_seg_scanner_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Width of a counter that spans 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_scan_timer.sv
// Slot counter and digit index for the display scan; flags the last cycle of
// every slot and of every frame.
module scan_timer
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  localparam int CW = cnt_width(REFRESH_DIV),
  localparam int IW = cnt_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt_q,
  output logic [IW-1:0] idx_q,
  output logic          slot_end,
  output logic          frame_end
);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_d;
  logic [IW-1:0] idx_d;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering
// and a blanking gap at the start of every digit slot.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_BLANK | first BLANK_CYCLES of a slot, all anodes off
//   ST_DRIVE | remainder of the slot, current digit driven if enabled
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [8*NUM_DIGITS-1:0] Seg_Data,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   Digit_En,
  output logic [7:0]              Seg,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    Frame_Done,
  output logic                    Load_Pending
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0]           BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0]   AN_OFF     = {NUM_DIGITS{1'b1}};
  localparam logic [8*NUM_DIGITS-1:0] BUF_OFF    = {NUM_DIGITS{SEG_OFF}};

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          slot_end;
  logic          frame_end;

  scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan_timer (
    .clk      (Clk),
    .reset    (Reset),
    .cnt_q    (cnt_q),
    .idx_q    (idx_q),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  logic [0:0]              state_q, state_d;
  logic [8*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [8*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    lp_q, lp_d;
  logic                    frame_done_q, frame_done_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    lit;

  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      state_d = ST_BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      state_d = ST_DRIVE;
    end
  end

  // The frame boundary is the cycle Frame_Done is high; a Load in that same
  // cycle goes straight to the display so it is not held back a whole frame.
  always_comb begin
    pend_d       = pend_q;
    disp_d       = disp_q;
    lp_d         = lp_q;
    frame_done_d = frame_end;
    if (frame_done_q && lp_q) begin
      disp_d = pend_q;
    end
    if (frame_done_q) begin
      lp_d = 1'b0;
    end
    if (Load) begin
      pend_d = Seg_Data;
      if (frame_done_q) begin
        disp_d = Seg_Data;
      end else begin
        lp_d = 1'b1;
      end
    end
  end

  always_comb begin
    lit   = (state_q == ST_DRIVE) && Digit_En[idx_q];
    seg_d = lit ? disp_q[idx_q*8 +: 8] : SEG_OFF;
    an_d  = AN_OFF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_BLANK;
      pend_q       <= BUF_OFF;
      disp_q       <= BUF_OFF;
      lp_q         <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      lp_q         <= lp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign Seg          = seg_q;
  assign An           = an_q;
  assign Frame_Done   = frame_done_q;
  assign Load_Pending = lp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed vector table, hand-written reset
// sequence and randomized traffic against a cycle-position reference model.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FP = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seg_data = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .Clk         (clk),
    .Reset       (reset),
    .Seg_Data    (seg_data),
    .Load        (load),
    .Digit_En    (digit_en),
    .Seg         (seg),
    .An          (an),
    .Frame_Done  (frame_done),
    .Load_Pending(load_pending)
  );

  // Reference model: t counts cycles since reset release; the displayed
  // position is pure arithmetic on t, buffers follow the commit rules.
  logic [7:0] m_disp[ND];
  logic [7:0] m_pend[ND];
  logic [7:0] p_disp[ND];
  logic [3:0] p_en;
  logic       m_lp;
  int         t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] es;
    logic [3:0] ea;
    int p, dig, ph;
    es = 8'hFF;
    ea = 4'hF;
    if (t > 0) begin
      p   = t - 1;
      dig = (p / RD) % ND;
      ph  = p % RD;
      if (ph >= BC && p_en[dig]) begin
        es = p_disp[dig];
        ea = ~(4'b0001 << dig);
      end
    end
    check("seg", seg, es);
    check("an", an, ea);
    check("frame_done", frame_done, (t > 0 && t % FP == 0));
    check("load_pending", load_pending, m_lp);
  endtask

  task automatic step(input logic ld, input logic [31:0] data, input logic [3:0] en);
    logic fd;
    check_outputs();
    load     = ld;
    seg_data = data;
    digit_en = en;
    for (int i = 0; i < ND; i++) p_disp[i] = m_disp[i];
    p_en = en;
    fd = (t > 0 && t % FP == 0);
    if (fd) begin
      if (m_lp) for (int i = 0; i < ND; i++) m_disp[i] = m_pend[i];
      m_lp = 1'b0;
    end
    if (ld) begin
      for (int i = 0; i < ND; i++) m_pend[i] = data[8*i +: 8];
      if (fd) begin
        for (int i = 0; i < ND; i++) m_disp[i] = data[8*i +: 8];
      end else begin
        m_lp = 1'b1;
      end
    end
    t++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    load  = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_seg", seg, 8'hFF);
    check("rst_an", an, 4'hF);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_load_pending", load_pending, 1'b0);
    reset = 1'b0;
    t     = 0;
    m_lp  = 1'b0;
    p_en  = 4'h0;
    for (int i = 0; i < ND; i++) begin
      m_disp[i] = 8'hFF;
      m_pend[i] = 8'hFF;
      p_disp[i] = 8'hFF;
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  en;
    logic [7:0]  load_phase;
    logic [7:0]  old_d3;
    logic [31:0] exp_seg;
    logic [15:0] exp_an;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vec_t v;
    int   first_fd;
    int   kk, f, dig, show_f;
    logic [3:0] en;

    vecs[0] = '{data: 32'hC0F9A4B0, en: 4'hF,    load_phase: 8'd5,  old_d3: 8'hFF,
                exp_seg: 32'hC0F9A4B0, exp_an: 16'h7BDE};
    vecs[1] = '{data: 32'h9299B0A4, en: 4'hF,    load_phase: 8'd17, old_d3: 8'hC0,
                exp_seg: 32'h9299B0A4, exp_an: 16'h7BDE};
    vecs[2] = '{data: 32'h82F88090, en: 4'hF,    load_phase: 8'd0,  old_d3: 8'h92,
                exp_seg: 32'h82F88090, exp_an: 16'h7BDE};
    vecs[3] = '{data: 32'h00127F01, en: 4'b1010, load_phase: 8'd9,  old_d3: 8'h82,
                exp_seg: 32'h00FF7FFF, exp_an: 16'h7FDF};

    // Idle after reset: dark display, Frame_Done every FP cycles.
    do_reset(3);
    repeat (70) step(1'b0, 32'h0, 4'hF);

    for (int r = 0; r < 4; r++) begin
      v = vecs[r];
      while (!(t > 0 && t % FP == 0)) step(1'b0, 32'h0, v.en);
      show_f = (v.load_phase == 0) ? 0 : 1;
      for (int k = 0; k < 2 * FP; k++) begin
        kk = k % FP;
        f  = k / FP;
        if (k == int'(v.load_phase) + 1)
          check("vec_load_pending", load_pending, (v.load_phase == 0) ? 1'b0 : 1'b1);
        if (f == 0 && kk == 27 && v.load_phase > 0 && v.load_phase < 26)
          check("vec_old_digit3", seg, v.old_d3);
        if (f == show_f && kk % RD == 3) begin
          dig = kk / RD;
          check("vec_seg", seg, v.exp_seg[8*dig +: 8]);
          check("vec_an", an, v.exp_an[4*dig +: 4]);
        end
        step(k == int'(v.load_phase), v.data, v.en);
      end
    end

    // Reset during digit 2 DRIVE with data pending: pending is discarded.
    do_reset(2);
    for (int k = 0; k < 21; k++) step(k == 3, 32'h11223344, 4'hF);
    check("pre_reset_load_pending", load_pending, 1'b1);
    do_reset(1);
    first_fd = -1;
    for (int k = 0; k < 40; k++) begin
      if (frame_done && first_fd < 0) first_fd = t;
      step(1'b0, 32'h0, 4'hF);
    end
    check("first_frame_done_after_reset", first_fd, 32);

    // Randomized traffic, including held Load, Digit_En changes and resets.
    en = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) en = 4'($urandom_range(0, 15));
      step($urandom_range(0, 5) == 0, $urandom, en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
